// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, FSM encoding and score compare for the CNN output stage
package cnn_pkg;
   localparam logic [7:0] SEG7_0 = 8'hC0, SEG7_1 = 8'hF9, SEG7_2 = 8'hA4, SEG7_3 = 8'hB0, SEG7_4 = 8'h99;
   localparam logic [7:0] SEG7_5 = 8'h92, SEG7_6 = 8'h82, SEG7_7 = 8'hF8, SEG7_8 = 8'h80, SEG7_9 = 8'h90;
   localparam logic [7:0] SEG7_DASH = 8'hBF, SEG7_BLANK = 8'hFF;
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   // flipping the sign bit turns a two's complement compare into an unsigned one
   function automatic logic gt(input logic [63:0] a, input logic [63:0] b, input logic sgn, input int w);
      logic [63:0] f;
      f = {63'd0, sgn} << (w - 1);
      return (a ^ f) > (b ^ f);
   endfunction
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: class index to active-low 7-segment code {dp,g..a}, dash above 9
module seg7_encode
   import cnn_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       seg
);
   logic [31:0] v;
   assign v = 32'(idx);
   always_comb begin
      case (v)
         0: seg = SEG7_0;
         1: seg = SEG7_1;
         2: seg = SEG7_2;
         3: seg = SEG7_3;
         4: seg = SEG7_4;
         5: seg = SEG7_5;
         6: seg = SEG7_6;
         7: seg = SEG7_7;
         8: seg = SEG7_8;
         9: seg = SEG7_9;
         default: seg = SEG7_DASH;
      endcase
   end
endmodule

// File: rtl/argmax_stream_classifier.sv
// argmax_stream_classifier: streaming argmax over one frame of class scores,
// result (index, score, 7-seg code, framing error) presented through valid/ready
module argmax_stream_classifier
   import cnn_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int NUM_CLASS  = 10,
   parameter bit SIGNED_CMP = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(NUM_CLASS)-1:0] out_class,
   output logic [DATA_W-1:0]            out_score,
   output logic [7:0]                   out_seg,
   output logic                         out_err
);
   localparam int IDX_W = $clog2(NUM_CLASS);
   localparam int CNT_W = $clog2(NUM_CLASS + 1);
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [DATA_W-1:0] max_q, max_n, res_score;
   logic [IDX_W-1:0] idx_q, idx_n, res_idx;
   logic take, full, first, upd, force_end, ld, res_err;
   logic [7:0] seg;
   seg7_encode #(.IDX_W(IDX_W)) u_seg (.idx(res_idx), .seg(seg));
   assign full = cnt == CNT_W'(NUM_CLASS);
   // a full frame without in_last refuses the extra beat; it opens the next frame
   assign in_ready = state == IDLE || (state == ACCUM && !full);
   assign out_valid = state == HOLD;
   always_comb begin
      take = in_valid && in_ready;
      first = state == IDLE;
      force_end = state == ACCUM && full && in_valid;
      upd = first || gt(64'(in_data), 64'(max_q), SIGNED_CMP, DATA_W);
      max_n = upd ? in_data : max_q;
      idx_n = first ? '0 : upd ? IDX_W'(cnt) : idx_q;
      cnt_n = first ? CNT_W'(1) : cnt + 1'b1;
      ld = force_end || (take && in_last);
      res_score = force_end ? max_q : max_n;
      res_idx = force_end ? idx_q : idx_n;
      res_err = force_end || cnt_n != CNT_W'(NUM_CLASS);
      state_n = ld ? HOLD : (take && first) ? ACCUM : (out_valid && out_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         max_q <= '0;
         idx_q <= '0;
         out_class <= '0;
         out_score <= '0;
         out_seg <= SEG7_BLANK;
         out_err <= 1'b0;
      end else begin
         state <= state_n;
         if (take) begin
            cnt <= cnt_n;
            max_q <= max_n;
            idx_q <= idx_n;
         end else if (out_valid) cnt <= '0;
         if (ld) begin
            out_class <= res_idx;
            out_score <= res_score;
            out_seg <= seg;
            out_err <= res_err;
         end
      end
   end
endmodule
